ifetch: RTL and testbench
=========================

# ifetch

Instruction fetch unit: the requesting side of the instruction memory interface. It owns the program counter, drives the word address and read-enable (`imemsrc`) into the single-cycle-latency instruction memory, and presents each returned instruction with its PC to the decode stage over a valid/ready handshake. It also handles control-flow redirects (jump/branch targets) and halt, and counts retired fetches for the performance counters.

## Interface
- `PC_RESET`, 32'h0040_0000: first PC fetched after reset; also the base of the memory image.
- `clk` input 1: clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `imemsrc` output 1: memory read enable; the memory registers `ins[imem_addr]` into `inst_in` on the next rising edge when high, holds otherwise.
- `imem_addr` output 32: word index into the memory, `(addr - PC_RESET) >> 2`.
- `inst_in` input 32: registered instruction word from memory.
- `redirect` input 1: one-cycle pulse, restart fetch at `redirect_pc`.
- `redirect_pc` input 32: redirect target; bits [1:0] ignored (treated as 0).
- `halt` input 1: stop issuing new fetches.
- `out_valid` output 1: `out_inst`/`out_pc` hold a valid instruction.
- `out_ready` input 1: decode accepts the instruction this cycle.
- `out_inst` output 32: instruction, wired directly from `inst_in`.
- `out_pc` output 32: byte address of `out_inst`.
- `fetch_count` output 32: number of accepted instructions.

## Operation
- State register: BOOT, RUN, HALT. Reset → BOOT. BOOT → RUN after one cycle, unconditionally. RUN → HALT when `halt`=1 and `redirect`=0. HALT → RUN only on `redirect`. `rst` overrides everything.
- Internal registers: `pc_q` (next PC to issue), `out_pc_q`, `out_valid_q`, `fetch_count`.
- `addr` = `redirect ? {redirect_pc[31:2],2'b00} : pc_q`.
- `issue` = `redirect`, or (state==RUN and `halt`=0 and (`out_valid_q`=0 or `out_ready`=1)).
- `imemsrc` = `issue` (combinational). `imem_addr` is always driven from `addr`, even when `imemsrc`=0.
- On `issue`: `out_pc_q` ← `addr`, `pc_q` ← `addr + 4` (mod 2^32), `out_valid_q` ← 1.
- When not issuing and the output is accepted: `out_valid_q` ← 0.
- `out_valid` = `out_valid_q & ~redirect`. An instruction presented in a redirect cycle is squashed, even if `out_ready`=1.
- `out_inst` = `inst_in`. Because `imemsrc`=0 holds the memory register, an unaccepted instruction stays stable under backpressure.
- `fetch_count` += 1 when `out_valid & out_ready`. It wraps at 2^32.
- HALT: the buffered instruction, if any, is still presented until accepted. Nothing further is issued.

## Timing
- Reset values: `imemsrc`=0, `out_valid`=0, `out_pc`=0, `fetch_count`=0, `pc_q`=`PC_RESET`, state=BOOT.
- Cycle 0 is the first cycle with `rst`=0. It is spent in BOOT with no issue.
- Cycle 1: first issue at `PC_RESET`.
- Cycle 2: first `out_valid`=1.
- Fetch-to-valid latency is one cycle. Throughput is one instruction per cycle while `out_ready`=1.
- Redirect in cycle t:
  - The memory is addressed at the target in cycle t.
  - The target instruction is valid in cycle t+1.
  - Any in-flight or buffered instruction is dropped and not counted.
- Redirect and `halt` in the same cycle: the redirect issues and the state stays/returns to RUN. `halt` is re-sampled in the next cycle.
- `rst` mid-stream: all registers return to reset values at that edge. The output instruction is discarded.

## Test plan
- Reset release, `out_ready`=1 tied, memory `ins[i]`=i+0x100 → cycle 2 `out_pc`=0x00400000, `out_inst`=0x100. Each following cycle +4 / +1. `fetch_count`=10 after 10 accepts.
- Backpressure: `out_ready`=0 for 3 cycles while `out_pc`=0x00400008 → `imemsrc`=0, `out_inst`=0x102 stable, `fetch_count` unchanged. Release → 0x0040000C the next cycle.
- Redirect to 0x00400040 while `out_pc`=0x00400010 and `out_ready`=1 → `out_valid`=0 that cycle, 0x00400010 not counted. Next cycle `out_pc`=0x00400040, `out_inst`=0x110.
- Redirect with misaligned `redirect_pc`=0x00400046 → `imem_addr`=0x11, `out_pc`=0x00400044.
- `halt` asserted with an instruction buffered and `out_ready`=0 → that instruction is held. After acceptance, `out_valid`=0 and `imemsrc`=0 indefinitely. Redirect to 0x00400000 → resumes, `out_inst`=0x100.
- `rst` pulsed mid-run at `out_pc`=0x00400020 → next cycle all outputs are at reset values, `fetch_count`=0. The first instruction reappears in cycle 2 after release.

Source files
------------

// File: rtl/ifetch.sv
// ---------------------------------------------------------------------------
// ifetch -- instruction fetch unit
//
// This block is the requesting side of a single-cycle-latency instruction
// memory. It owns the program counter and issues one word read per cycle.
// Each returned word is presented to decode, together with its byte PC,
// over a valid/ready handshake. It also handles redirects (jump/branch
// targets) and halt, and counts the instructions that decode accepts.
//
// Ports
//   clk          in   1  rising-edge clock
//   rst          in   1  synchronous, active-high reset
//   imemsrc      out  1  memory read enable (memory registers word next edge)
//   imem_addr    out 32  word index into memory: (addr - PC_RESET) >> 2
//   inst_in      in  32  registered instruction word from memory
//   redirect     in   1  one-cycle pulse: restart fetch at redirect_pc
//   redirect_pc  in  32  redirect target; low two bits are ignored
//   halt         in   1  stop issuing new fetches
//   out_valid    out  1  out_inst/out_pc hold a valid instruction
//   out_ready    in   1  decode accepts the instruction this cycle
//   out_inst     out 32  instruction (wired straight from inst_in)
//   out_pc       out 32  byte address of out_inst
//   fetch_count  out 32  number of accepted instructions (wraps)
// ---------------------------------------------------------------------------
module ifetch #(
  parameter logic [31:0] PC_RESET = 32'h0040_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imemsrc,
  output logic [31:0] imem_addr,
  input  logic [31:0] inst_in,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_pc;
  logic [31:0] r_out_pc;
  logic        r_out_valid;
  logic [31:0] r_fetch_count;

  logic [31:0] w_addr;
  logic [31:0] w_addr_off;
  logic        w_issue;
  logic        w_accept;

  // Redirect target is forced word-aligned; masking keeps every bit of the
  // input in use instead of leaving the low bits dangling.
  assign w_addr     = redirect ? (redirect_pc & 32'hFFFF_FFFC) : r_pc;
  assign w_addr_off = w_addr - PC_RESET;

  // A new fetch may only overwrite the memory output register when the word
  // it currently holds is either absent or being consumed this cycle.
  // A redirect always issues: whatever sits in the register is stale.
  assign w_issue = redirect |
                   ((r_state == ST_RUN) & ~halt & (~r_out_valid | out_ready));

  assign imemsrc   = w_issue;
  assign imem_addr = w_addr_off >> 2;

  // The word presented during a redirect belongs to the old path.
  assign out_valid   = r_out_valid & ~redirect;
  assign out_inst    = inst_in;
  assign out_pc      = r_out_pc;
  assign fetch_count = r_fetch_count;

  assign w_accept = out_valid & out_ready;

  // -------------------------------------------------------------------------
  // Control state: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN: begin
        // A simultaneous redirect wins; halt is looked at again next cycle.
        if (halt && !redirect) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (redirect) begin
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Fetch stage -> output stage boundary (memory latency is one cycle, so the
  // PC recorded at issue lines up with inst_in on the following cycle)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc        <= PC_RESET;
      r_out_pc    <= 32'd0;
      r_out_valid <= 1'b0;
    end else if (w_issue) begin
      r_pc        <= w_addr + 32'd4;
      r_out_pc    <= w_addr;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      // Not issuing: a ready cycle drains the buffered word (if any).
      r_out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_count <= 32'd0;
    end else if (w_accept) begin
      r_fetch_count <= r_fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;

  localparam logic [31:0] B = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imemsrc;
  logic [31:0] imem_addr;
  logic [31:0] inst_in = 32'd0;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  ifetch #(.PC_RESET(B)) dut (
    .clk(clk), .rst(rst), .imemsrc(imemsrc), .imem_addr(imem_addr),
    .inst_in(inst_in), .redirect(redirect), .redirect_pc(redirect_pc),
    .halt(halt), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: ins[i] = i + 0x100, registered read when enabled.
  always @(posedge clk) begin
    if (imemsrc) inst_in <= imem_addr + 32'h100;
  end

  typedef struct {
    logic        chk;
    logic        t_rst;
    logic        t_redir;
    logic [31:0] t_rpc;
    logic        t_halt;
    logic        t_ready;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_src;
    logic [31:0] e_addr;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic c, input logic r, input logic rd,
                              input logic [31:0] rp, input logic h,
                              input logic rdy, input logic v,
                              input logic [31:0] pc, input logic [31:0] ins,
                              input logic s, input logic [31:0] a,
                              input logic [31:0] cn);
    vec_t t;
    t.chk = c; t.t_rst = r; t.t_redir = rd; t.t_rpc = rp; t.t_halt = h;
    t.t_ready = rdy; t.e_valid = v; t.e_pc = pc; t.e_inst = ins;
    t.e_src = s; t.e_addr = a; t.e_cnt = cn;
    tbl.push_back(t);
  endfunction

  task automatic cmp(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input int idx,
                               input logic v, input logic [31:0] pc,
                               input logic [31:0] ins, input logic s,
                               input logic [31:0] a, input logic [31:0] cn);
    cmp({tag, ".out_valid"}, idx, {31'd0, out_valid}, {31'd0, v});
    cmp({tag, ".imemsrc"}, idx, {31'd0, imemsrc}, {31'd0, s});
    cmp({tag, ".imem_addr"}, idx, imem_addr, a);
    cmp({tag, ".out_pc"}, idx, out_pc, pc);
    cmp({tag, ".fetch_count"}, idx, fetch_count, cn);
    if (v) cmp({tag, ".out_inst"}, idx, out_inst, ins);
  endtask

  // Behavioural reference: a running/halted flag, the word waiting for
  // decode (if any), the next sequential PC, and the accept count.
  logic        m_booted, m_halted, m_have;
  logic [31:0] m_have_pc, m_next_pc, m_count;

  function automatic void model_reset();
    m_booted = 1'b0; m_halted = 1'b0; m_have = 1'b0;
    m_have_pc = 32'd0; m_next_pc = B; m_count = 32'd0;
  endfunction

  initial begin
    logic        e_src, e_valid, rd, h, rdy, r;
    logic [31:0] tgt, fetch_pc, e_inst, rp;

    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; halt = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // ---------------- directed table ----------------
    add(1,0,0,0,0,1, 0,0,0,0,0,0);                         // c0: BOOT
    add(1,0,0,0,0,1, 0,0,0,1,0,0);                         // c1: first issue
    add(1,0,0,0,0,1, 1,B,'h100,1,1,0);                     // c2: first valid
    add(1,0,0,0,0,1, 1,B+4,'h101,1,2,1);
    add(1,0,0,0,0,0, 1,B+8,'h102,0,3,2);                   // backpressure
    add(1,0,0,0,0,0, 1,B+8,'h102,0,3,2);
    add(1,0,0,0,0,0, 1,B+8,'h102,0,3,2);
    add(1,0,0,0,0,1, 1,B+8,'h102,1,3,2);                   // release
    add(1,0,0,0,0,1, 1,B+'hC,'h103,1,4,3);
    add(1,0,1,B+'h40,0,1, 0,B+'h10,0,1,'h10,4);            // redirect squash
    add(1,0,0,0,0,1, 1,B+'h40,'h110,1,'h11,4);
    add(1,0,1,B+'h46,0,1, 0,B+'h44,0,1,'h11,5);            // misaligned target
    add(1,0,0,0,0,1, 1,B+'h44,'h111,1,'h12,5);
    add(1,0,0,0,1,0, 1,B+'h48,'h112,0,'h13,6);             // halt, held
    add(1,0,0,0,1,0, 1,B+'h48,'h112,0,'h13,6);
    add(1,0,0,0,0,1, 1,B+'h48,'h112,0,'h13,6);             // accepted in HALT
    add(1,0,0,0,0,1, 0,B+'h48,0,0,'h13,7);
    add(1,0,0,0,0,1, 0,B+'h48,0,0,'h13,7);
    add(1,0,1,B,0,1, 0,B+'h48,0,1,0,7);                    // resume
    add(1,0,0,0,0,1, 1,B,'h100,1,1,7);
    for (int k = 1; k <= 7; k++)
      add(1,0,0,0,0,1, 1,B+4*k,'h100+k,1,k+1,7+k);
    add(0,1,0,0,0,1, 0,0,0,0,0,0);                         // rst mid-stream
    add(1,0,0,0,0,1, 0,0,0,0,0,0);
    add(1,0,0,0,0,1, 0,0,0,1,0,0);
    add(1,0,0,0,0,1, 1,B,'h100,1,1,0);
    add(1,0,0,0,0,1, 1,B+4,'h101,1,2,1);
    add(1,0,1,B+'h80,1,1, 0,B+8,0,1,'h20,2);               // redirect + halt
    add(1,0,0,0,1,1, 1,B+'h80,'h120,0,'h21,2);             // halt re-sampled
    add(1,0,0,0,0,1, 0,B+'h80,0,0,'h21,3);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].t_rst; redirect = tbl[i].t_redir;
      redirect_pc = tbl[i].t_rpc; halt = tbl[i].t_halt;
      out_ready = tbl[i].t_ready;
      @(negedge clk);
      if (tbl[i].chk)
        check_outputs("tbl", i, tbl[i].e_valid, tbl[i].e_pc, tbl[i].e_inst,
                      tbl[i].e_src, tbl[i].e_addr, tbl[i].e_cnt);
      @(posedge clk);
      #1;
    end

    // ---------------- randomized against reference ----------------
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      r   = (c == 0) || ($urandom_range(0, 99) < 1);
      rd  = ($urandom_range(0, 99) < 6);
      h   = ($urandom_range(0, 99) < 15);
      rdy = ($urandom_range(0, 99) < 70);
      rp  = B + 4 * $urandom_range(0, 255) + $urandom_range(0, 3);

      tgt      = {rp[31:2], 2'b00};
      fetch_pc = rd ? tgt : m_next_pc;
      e_src    = rd || (m_booted && !m_halted && !h && (!m_have || rdy));
      e_valid  = m_have && !rd;
      e_inst   = ((m_have_pc - B) >> 2) + 32'h100;

      rst = r; redirect = rd; redirect_pc = rp; halt = h; out_ready = rdy;
      @(negedge clk);
      if (!r)
        check_outputs("rnd", c, e_valid, m_have_pc, e_inst, e_src,
                      (fetch_pc - B) >> 2, m_count);

      if (r) begin
        model_reset();
      end else begin
        if (e_valid && rdy) m_count = m_count + 1;
        if (e_src) begin
          m_have = 1'b1; m_have_pc = fetch_pc; m_next_pc = fetch_pc + 4;
        end else if (rdy) begin
          m_have = 1'b0;
        end
        if (rd) m_halted = 1'b0;
        else if (m_booted && h) m_halted = 1'b1;
        m_booted = 1'b1;
      end
      @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
